game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Parametrised game-flow controller, successor to the fixed 3-bit level/world FSM.
//  Sequences IDLE -> LOAD -> PLAY through N worlds x M levels with a life counter and pause.
//  Holds timed win/death banners and emits a one-cycle load_level strobe so obstacle/scroll blocks re-seed.
//  Sits between the keyboard/collision logic and the video, audio and object blocks.
// PARAMETERS
//  NUM_WORLDS        2    worlds per game (>=1)
//  LEVELS_PER_WORLD  4    levels per world (>=1)
//  START_LIVES       3    lives at game start (>=1)
//  BANNER_TICKS      120  tick pulses a win/death banner is held (>=1)
// PORTS
//  clk          in   1                        system clock
//  rst          in   1                        reset, synchronous, active-low
//  tick         in   1                        frame-rate enable pulse, one cycle
//  start        in   1                        start/continue request, level
//  pause        in   1                        pause toggle request, pulse
//  level_passed in   1                        player reached exit, pulse
//  lose         in   1                        player collided fatally, pulse
//  level        out  clog2(LEVELS_PER_WORLD)  current level, 0-based
//  world        out  clog2(NUM_WORLDS)        current world, 0-based
//  lives        out  clog2(START_LIVES+1)     remaining lives
//  game_status  out  3                        0 play,1 lvl win,2 world win,3 game win,4 over,5 idle,6 paused
//  objects_en   out  1                        1 only in PLAY; gates player/obstacle motion
//  load_level   out  1                        one-cycle strobe on entry to LOAD
// BEHAVIOUR
//  Reset (rst==0 at posedge): state IDLE, level=0, world=0, lives=START_LIVES,
//   game_status=5, objects_en=0, load_level=0, banner counter=0.
//  All outputs are registered. game_status/objects_en update the cycle after the state change.
//  IDLE: start==1 -> LOAD.
//  LOAD: load_level=1 for exactly one cycle, then PLAY.
//  PLAY: pause -> PAUSE. level_passed -> LVL_WIN if level<LEVELS_PER_WORLD-1,
//   else WORLD_WIN if world<NUM_WORLDS-1, else GAME_WIN.
//   lose -> DEAD with lives-1 if lives>1; lose with lives==1 -> OVER with lives=0.
//   level_passed and lose in the same cycle: level_passed wins; lose is dropped.
//   pause together with either: the event wins; pause is dropped.
//  PAUSE: status 6; the next pause pulse -> PLAY. level_passed/lose are ignored.
//  LVL_WIN/WORLD_WIN/DEAD: counter loads BANNER_TICKS-1 on entry and decrements on tick.
//   At 0 with tick: LVL_WIN -> level+1 -> LOAD.
//   WORLD_WIN -> level=0, world+1 -> LOAD.
//   DEAD -> same level -> LOAD. DEAD reports status 4 only in OVER; during DEAD it reports 0 with objects_en=0.
//  GAME_WIN/OVER: held until start rises (0->1 edge), then -> IDLE with counters reset.
//  Event pulses outside PLAY (and pause outside PLAY/PAUSE) are ignored.
//  tick is ignored outside banner states. No counter ever wraps; bounds are checked before increment.
//  Reset mid-banner or mid-LOAD: returns to IDLE immediately; no load_level is emitted.
// CONFIGURATION
//  `CONTINUE_EN defined: in OVER, a start rising edge within BANNER_TICKS ticks of entry
//   restores lives=START_LIVES, sets level=0, keeps world, -> LOAD.
//   After the window expires, start -> IDLE as normal.
//  Not defined: OVER always returns to IDLE; the window counter is not built.
// STRUCTURE
//  game_pkg: state enum, game_status encodings (ST_PLAY..ST_PAUSED), width helper constants.
//  One sub-module, banner_timer: load / tick-decrement / done, width clog2(BANNER_TICKS).
//   Shared by the banner and continue-window logic.
//  Rest is a single FSM plus level/world/lives registers.
// TESTING
//  Defaults, BANNER_TICKS=4. rst low 2 cycles -> status=5, lives=3, level=0, world=0, load_level=0.
//  start=1 -> load_level pulses 1 cycle -> status=0, objects_en=1.
//   level_passed -> status=1; 4 ticks -> level=1, load_level pulse.
//  Reach level 3 and pass -> status=2; after 4 ticks -> world=1, level=0.
//   Pass all 4 levels of world 1 -> status=3 held; start edge -> status=5.
//  Three lose pulses, each followed by a full banner -> lives 2, 1, 0 -> status=4, objects_en=0.
//   With CONTINUE_EN: start within 4 ticks -> lives=3, world kept, load_level pulse.
//  level_passed and lose in the same cycle at lives=1 -> status=1, lives stays 1.
//   pause -> status=6; lose during pause ignored; pause -> status=0.
//  Assert rst low during a DEAD banner (counter=2) -> next cycle status=5, lives=3, no load_level.

Source files
------------

// File: rtl/game_sequencer_pkg.sv
// game_sequencer_pkg: FSM states, status encodings and width helpers for game_sequencer.
package game_sequencer_pkg;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_PLAY, S_PAUSE, S_LVL_WIN, S_WORLD_WIN, S_GAME_WIN, S_DEAD, S_OVER
   } state_t;

   localparam logic [2:0] ST_PLAY      = 3'd0;
   localparam logic [2:0] ST_LVL_WIN   = 3'd1;
   localparam logic [2:0] ST_WORLD_WIN = 3'd2;
   localparam logic [2:0] ST_GAME_WIN  = 3'd3;
   localparam logic [2:0] ST_OVER      = 3'd4;
   localparam logic [2:0] ST_IDLE      = 3'd5;
   localparam logic [2:0] ST_PAUSED    = 3'd6;

   // Never returns 0 so single-value ranges still get a 1-bit register.
   function automatic int wof(input int n);
      return n < 2 ? 1 : $clog2(n);
   endfunction

   // LOAD and DEAD report play so the banner only shows on real wins and game over.
   function automatic logic [2:0] status_of(input state_t s);
      return s == S_IDLE      ? ST_IDLE      :
             s == S_PAUSE     ? ST_PAUSED    :
             s == S_LVL_WIN   ? ST_LVL_WIN   :
             s == S_WORLD_WIN ? ST_WORLD_WIN :
             s == S_GAME_WIN  ? ST_GAME_WIN  :
             s == S_OVER      ? ST_OVER      : ST_PLAY;
   endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// game_sequencer_if: control inputs and game-state outputs of game_sequencer.
interface game_sequencer_if #(
   parameter int LW = 2,
   parameter int WW = 1,
   parameter int NW = 2
);
   logic          tick;
   logic          start;
   logic          pause;
   logic          level_passed;
   logic          lose;
   logic [LW-1:0] level;
   logic [WW-1:0] world;
   logic [NW-1:0] lives;
   logic [2:0]    game_status;
   logic          objects_en;
   logic          load_level;

   modport master (
      output tick, start, pause, level_passed, lose,
      input  level, world, lives, game_status, objects_en, load_level
   );

   modport slave (
      input  tick, start, pause, level_passed, lose,
      output level, world, lives, game_status, objects_en, load_level
   );
endinterface

// File: rtl/game_sequencer_banner_timer.sv
// banner_timer: loadable down-counter that decrements on tick and flags zero; never wraps.
module banner_timer
   import game_sequencer_pkg::*;
#(
   parameter int TICKS = 120
)(
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic tick_i,
   output logic zero_o
);
   localparam int CW = wof(TICKS);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst) cnt_q <= '0;
      else if (load_i) cnt_q <= CW'(TICKS - 1);
      else if (tick_i && cnt_q != '0) cnt_q <= cnt_q - CW'(1);
   end

   assign zero_o = cnt_q == '0;
endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: IDLE/LOAD/PLAY game-flow FSM over worlds x levels with lives, pause and timed banners.
// Define CONTINUE_EN to let a start edge shortly after game over resume the current world.
module game_sequencer
   import game_sequencer_pkg::*;
#(
   parameter int NUM_WORLDS       = 2,
   parameter int LEVELS_PER_WORLD = 4,
   parameter int START_LIVES      = 3,
   parameter int BANNER_TICKS     = 120
)(
   input logic             clk,
   input logic             rst,
   game_sequencer_if.slave bus
);
   localparam int LW = wof(LEVELS_PER_WORLD);
   localparam int WW = wof(NUM_WORLDS);
   localparam int NW = wof(START_LIVES + 1);
   localparam logic [LW-1:0] LVL_LAST   = LW'(LEVELS_PER_WORLD - 1);
   localparam logic [WW-1:0] WLD_LAST   = WW'(NUM_WORLDS - 1);
   localparam logic [NW-1:0] LIVES_INIT = NW'(START_LIVES);

   state_t        state_q;
   logic [LW-1:0] level_q;
   logic [WW-1:0] world_q;
   logic [NW-1:0] lives_q;
   logic [2:0]    status_q;
   logic          objects_en_q;
   logic          load_level_q;
   logic          start_q;
   logic          load;
   logic          timed;
   logic          zero;
   logic          fire;
   logic          cont;
   logic          start_rise;

   // Every banner (and game over) is entered from PLAY on an event pulse.
   assign load       = state_q == S_PLAY && (bus.level_passed || bus.lose);
   assign fire       = timed && bus.tick && zero;
   assign start_rise = bus.start && !start_q;

`ifdef CONTINUE_EN
   logic window_q;

   always_ff @(posedge clk) begin
      window_q <= !rst ? 1'b0 : load | (window_q & ~fire);
   end

   assign timed = state_q inside {S_LVL_WIN, S_WORLD_WIN, S_DEAD, S_OVER};
   assign cont  = state_q == S_OVER && window_q;
`else
   assign timed = state_q inside {S_LVL_WIN, S_WORLD_WIN, S_DEAD};
   assign cont  = 1'b0;
`endif

   banner_timer #(.TICKS(BANNER_TICKS)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .tick_i (timed && bus.tick),
      .zero_o (zero)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         level_q      <= '0;
         world_q      <= '0;
         lives_q      <= LIVES_INIT;
         status_q     <= ST_IDLE;
         objects_en_q <= 1'b0;
         load_level_q <= 1'b0;
         start_q      <= 1'b0;
      end else begin
         start_q      <= bus.start;
         status_q     <= status_of(state_q);
         objects_en_q <= state_q == S_PLAY;
         load_level_q <= state_q == S_LOAD;
         case (state_q)
            S_IDLE: if (bus.start) state_q <= S_LOAD;
            S_LOAD: state_q <= S_PLAY;
            S_PLAY: begin
               if (bus.level_passed)
                  state_q <= level_q < LVL_LAST ? S_LVL_WIN : world_q < WLD_LAST ? S_WORLD_WIN : S_GAME_WIN;
               else if (bus.lose) begin
                  state_q <= lives_q > NW'(1) ? S_DEAD : S_OVER;
                  lives_q <= lives_q - NW'(1);
               end else if (bus.pause) state_q <= S_PAUSE;
            end
            S_PAUSE: if (bus.pause) state_q <= S_PLAY;
            S_LVL_WIN: if (fire) begin
               level_q <= level_q + LW'(1);
               state_q <= S_LOAD;
            end
            S_WORLD_WIN: if (fire) begin
               level_q <= '0;
               world_q <= world_q + WW'(1);
               state_q <= S_LOAD;
            end
            S_DEAD: if (fire) state_q <= S_LOAD;
            S_GAME_WIN, S_OVER: if (start_rise) begin
               level_q <= '0;
               lives_q <= LIVES_INIT;
               world_q <= cont ? world_q : '0;
               state_q <= cont ? S_LOAD : S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.level       = level_q;
   assign bus.world       = world_q;
   assign bus.lives       = lives_q;
   assign bus.game_status = status_q;
   assign bus.objects_en  = objects_en_q;
   assign bus.load_level  = load_level_q;
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed scenario tests for game_sequencer with BANNER_TICKS=4.
module tb_game_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   nchk = 0;
   int   nerr = 0;

   game_sequencer_if #(.LW(2), .WW(1), .NW(2)) bus ();

   game_sequencer #(
      .NUM_WORLDS(2), .LEVELS_PER_WORLD(4), .START_LIVES(3), .BANNER_TICKS(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick = 1'b1;
         cyc(1);
         bus.tick = 1'b0;
         cyc(1);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus.tick = 1'b0; bus.start = 1'b0; bus.pause = 1'b0; bus.level_passed = 1'b0; bus.lose = 1'b0;
      cyc(2);
      rst = 1'b1;
   endtask

   task automatic begin_play();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(2);
   endtask

   task automatic pass_level();
      bus.level_passed = 1'b1;
      cyc(1);
      bus.level_passed = 1'b0;
      cyc(1);
      tick_n(4);
      cyc(1);
   endtask

   task automatic die_once();
      bus.lose = 1'b1;
      cyc(1);
      bus.lose = 1'b0;
      cyc(1);
      tick_n(4);
      cyc(1);
   endtask

   task automatic test_reset();
      do_reset();
      nchk++; if (bus.game_status !== 3'd5) begin nerr++; $display("FAIL reset_status got %0d want 5", bus.game_status); end
      nchk++; if (bus.lives !== 2'd3) begin nerr++; $display("FAIL reset_lives got %0d want 3", bus.lives); end
      nchk++; if (bus.level !== 2'd0 || bus.world !== 1'b0) begin nerr++; $display("FAIL reset_pos got L%0d W%0d want L0 W0", bus.level, bus.world); end
      nchk++; if (bus.load_level !== 1'b0 || bus.objects_en !== 1'b0) begin nerr++; $display("FAIL reset_strobes got ll=%b oe=%b want 0 0", bus.load_level, bus.objects_en); end
      bus.pause = 1'b1;
      cyc(1);
      bus.pause = 1'b0;
      cyc(2);
      nchk++; if (bus.game_status !== 3'd5) begin nerr++; $display("FAIL idle_pause_ignored got %0d want 5", bus.game_status); end
   endtask

   task automatic test_start();
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(1);
      nchk++; if (bus.load_level !== 1'b1) begin nerr++; $display("FAIL start_load_strobe got %b want 1", bus.load_level); end
      cyc(1);
      nchk++; if (bus.load_level !== 1'b0) begin nerr++; $display("FAIL start_strobe_one_cycle got %b want 0", bus.load_level); end
      nchk++; if (bus.game_status !== 3'd0 || bus.objects_en !== 1'b1) begin nerr++; $display("FAIL start_play got st=%0d oe=%b want 0 1", bus.game_status, bus.objects_en); end
   endtask

   task automatic test_level_win();
      bus.level_passed = 1'b1;
      cyc(1);
      bus.level_passed = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd1 || bus.objects_en !== 1'b0) begin nerr++; $display("FAIL lvl_win_status got st=%0d oe=%b want 1 0", bus.game_status, bus.objects_en); end
      tick_n(3);
      nchk++; if (bus.game_status !== 3'd1 || bus.level !== 2'd0) begin nerr++; $display("FAIL lvl_banner_hold got st=%0d L%0d want 1 L0", bus.game_status, bus.level); end
      tick_n(1);
      nchk++; if (bus.level !== 2'd1 || bus.load_level !== 1'b1) begin nerr++; $display("FAIL lvl_advance got L%0d ll=%b want L1 1", bus.level, bus.load_level); end
      cyc(1);
      nchk++; if (bus.game_status !== 3'd0 || bus.objects_en !== 1'b1) begin nerr++; $display("FAIL lvl_replay got st=%0d oe=%b want 0 1", bus.game_status, bus.objects_en); end
   endtask

   task automatic test_world_and_game_win();
      pass_level();
      pass_level();
      nchk++; if (bus.level !== 2'd3) begin nerr++; $display("FAIL reach_lvl3 got L%0d want L3", bus.level); end
      bus.level_passed = 1'b1;
      cyc(1);
      bus.level_passed = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd2) begin nerr++; $display("FAIL world_win_status got %0d want 2", bus.game_status); end
      tick_n(4);
      nchk++; if (bus.world !== 1'b1 || bus.level !== 2'd0 || bus.load_level !== 1'b1) begin nerr++; $display("FAIL world_advance got W%0d L%0d ll=%b want W1 L0 1", bus.world, bus.level, bus.load_level); end
      cyc(1);
      pass_level();
      pass_level();
      pass_level();
      bus.level_passed = 1'b1;
      cyc(1);
      bus.level_passed = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd3) begin nerr++; $display("FAIL game_win_status got %0d want 3", bus.game_status); end
      tick_n(5);
      nchk++; if (bus.game_status !== 3'd3 || bus.world !== 1'b1 || bus.level !== 2'd3) begin nerr++; $display("FAIL game_win_hold got st=%0d W%0d L%0d want 3 W1 L3", bus.game_status, bus.world, bus.level); end
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd5 || bus.world !== 1'b0 || bus.level !== 2'd0) begin nerr++; $display("FAIL game_win_to_idle got st=%0d W%0d L%0d want 5 W0 L0", bus.game_status, bus.world, bus.level); end
   endtask

   task automatic test_lives();
      do_reset();
      begin_play();
      bus.lose = 1'b1;
      cyc(1);
      bus.lose = 1'b0;
      cyc(1);
      nchk++; if (bus.lives !== 2'd2 || bus.game_status !== 3'd0 || bus.objects_en !== 1'b0) begin nerr++; $display("FAIL dead_banner got lives=%0d st=%0d oe=%b want 2 0 0", bus.lives, bus.game_status, bus.objects_en); end
      tick_n(4);
      nchk++; if (bus.load_level !== 1'b1 || bus.level !== 2'd0) begin nerr++; $display("FAIL dead_reload got ll=%b L%0d want 1 L0", bus.load_level, bus.level); end
      cyc(1);
      die_once();
      nchk++; if (bus.lives !== 2'd1 || bus.objects_en !== 1'b1) begin nerr++; $display("FAIL second_death got lives=%0d oe=%b want 1 1", bus.lives, bus.objects_en); end
      bus.lose = 1'b1;
      cyc(1);
      bus.lose = 1'b0;
      cyc(1);
      nchk++; if (bus.lives !== 2'd0 || bus.game_status !== 3'd4 || bus.objects_en !== 1'b0) begin nerr++; $display("FAIL game_over got lives=%0d st=%0d oe=%b want 0 4 0", bus.lives, bus.game_status, bus.objects_en); end
`ifdef CONTINUE_EN
      tick_n(2);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(1);
      nchk++; if (bus.lives !== 2'd3 || bus.load_level !== 1'b1 || bus.world !== 1'b0) begin nerr++; $display("FAIL continue got lives=%0d ll=%b W%0d want 3 1 W0", bus.lives, bus.load_level, bus.world); end
`else
      tick_n(2);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(1);
      nchk++; if (bus.lives !== 2'd3 || bus.game_status !== 3'd5 || bus.load_level !== 1'b0) begin nerr++; $display("FAIL over_to_idle got lives=%0d st=%0d ll=%b want 3 5 0", bus.lives, bus.game_status, bus.load_level); end
`endif
   endtask

   task automatic test_priority_and_pause();
      do_reset();
      begin_play();
      die_once();
      die_once();
      bus.level_passed = 1'b1;
      bus.lose = 1'b1;
      cyc(1);
      bus.level_passed = 1'b0;
      bus.lose = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd1 || bus.lives !== 2'd1) begin nerr++; $display("FAIL pass_beats_lose got st=%0d lives=%0d want 1 1", bus.game_status, bus.lives); end
      tick_n(4);
      cyc(1);
      bus.pause = 1'b1;
      cyc(1);
      bus.pause = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd6 || bus.objects_en !== 1'b0) begin nerr++; $display("FAIL pause_status got st=%0d oe=%b want 6 0", bus.game_status, bus.objects_en); end
      bus.lose = 1'b1;
      cyc(1);
      bus.lose = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd6 || bus.lives !== 2'd1) begin nerr++; $display("FAIL lose_in_pause got st=%0d lives=%0d want 6 1", bus.game_status, bus.lives); end
      bus.pause = 1'b1;
      cyc(1);
      bus.pause = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd0 || bus.objects_en !== 1'b1 || bus.level !== 2'd1) begin nerr++; $display("FAIL unpause got st=%0d oe=%b L%0d want 0 1 L1", bus.game_status, bus.objects_en, bus.level); end
      bus.pause = 1'b1;
      bus.lose = 1'b1;
      cyc(1);
      bus.pause = 1'b0;
      bus.lose = 1'b0;
      cyc(1);
      nchk++; if (bus.game_status !== 3'd4 || bus.lives !== 2'd0) begin nerr++; $display("FAIL lose_beats_pause got st=%0d lives=%0d want 4 0", bus.game_status, bus.lives); end
   endtask

   task automatic test_reset_mid_banner();
      int strobes;
      do_reset();
      begin_play();
      bus.lose = 1'b1;
      cyc(1);
      bus.lose = 1'b0;
      cyc(1);
      tick_n(1);
      rst = 1'b0;
      cyc(1);
      rst = 1'b1;
      nchk++; if (bus.game_status !== 3'd5 || bus.lives !== 2'd3 || bus.load_level !== 1'b0) begin nerr++; $display("FAIL reset_mid_dead got st=%0d lives=%0d ll=%b want 5 3 0", bus.game_status, bus.lives, bus.load_level); end
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         bus.tick = 1'b1;
         cyc(1);
         strobes += int'(bus.load_level);
         bus.tick = 1'b0;
         cyc(1);
         strobes += int'(bus.load_level);
      end
      nchk++; if (strobes != 0 || bus.game_status !== 3'd5) begin nerr++; $display("FAIL no_load_after_reset got strobes=%0d st=%0d want 0 5", strobes, bus.game_status); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_level_win();
      test_world_and_game_win();
      test_lives();
      test_priority_and_pause();
      test_reset_mid_banner();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule
